// File: rtl/shift_deserializer.sv
// MSB-first serial-to-parallel receiver with frame-start hunting, a valid/ready
// holding register and sticky overrun / frame-error flags.
module shift_deserializer #(
  parameter int WIDTH   = 8,
  parameter bit FREERUN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             SI,
  input  logic             SYNC,
  output logic [WIDTH-1:0] PO,
  output logic             PO_VALID,
  input  logic             PO_READY,
  output logic             OVERRUN,
  output logic             FRAMEERR,
  input  logic             ERR_CLR
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] bitcnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q;
  logic             overrun_q;
  logic             frameerr_q;

  logic [WIDTH-1:0] word_s;
  logic             complete_s;
  logic             load_s;
  logic             drop_s;
  logic             sync_err_s;

  // Completion, handshake and error qualifiers for the current edge
  always_comb begin
    word_s     = {shreg_q[WIDTH-2:0], SI};
    complete_s = 1'b0;
    sync_err_s = 1'b0;
    if (clken && (state_q == SHIFT)) begin
      complete_s = !SYNC && (bitcnt_q == LAST_CNT);
      sync_err_s = SYNC && (bitcnt_q != CNT_ZERO);
    end else begin
      complete_s = 1'b0;
      sync_err_s = 1'b0;
    end
    load_s = complete_s && (!po_valid_q || PO_READY);
    drop_s = complete_s && po_valid_q && !PO_READY;
  end

  // Receive FSM, holding register and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      bitcnt_q   <= CNT_ZERO;
      shreg_q    <= {WIDTH{1'b0}};
      po_q       <= {WIDTH{1'b0}};
      po_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      frameerr_q <= 1'b0;
    end else begin
      if (clken) begin
        case (state_q)
          HUNT: begin
            if (SYNC) begin
              shreg_q  <= word_s;
              bitcnt_q <= CNT_ONE;
              state_q  <= SHIFT;
            end
          end
          SHIFT: begin
            shreg_q <= word_s;
            if (SYNC) begin
              bitcnt_q <= CNT_ONE;
            end else if (bitcnt_q == LAST_CNT) begin
              bitcnt_q <= CNT_ZERO;
              state_q  <= FREERUN ? SHIFT : HUNT;
            end else begin
              bitcnt_q <= bitcnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q  <= HUNT;
            bitcnt_q <= CNT_ZERO;
          end
        endcase
      end

      // A completion on the handshake edge refills the register instead of emptying it
      if (load_s) begin
        po_q       <= word_s;
        po_valid_q <= 1'b1;
      end else if (po_valid_q && PO_READY) begin
        po_valid_q <= 1'b0;
      end

      if (drop_s) begin
        overrun_q <= 1'b1;
      end else if (ERR_CLR) begin
        overrun_q <= 1'b0;
      end

      if (sync_err_s) begin
        frameerr_q <= 1'b1;
      end else if (ERR_CLR) begin
        frameerr_q <= 1'b0;
      end
    end
  end

  assign PO       = po_q;
  assign PO_VALID = po_valid_q;
  assign OVERRUN  = overrun_q;
  assign FRAMEERR = frameerr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench: dut0 runs FREERUN=0, dut1 runs FREERUN=1; a negedge monitor
// pops expected words on every valid/ready handshake.
module tb_shift_deserializer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clken, si, sync, po_ready, err_clr;
  logic       sel1;
  logic [7:0] po0, po1;
  logic       po_valid0, po_valid1, overrun0, overrun1, frameerr0, frameerr1;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  shift_deserializer #(.WIDTH(8), .FREERUN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clken(clken && !sel1), .SI(si), .SYNC(sync),
    .PO(po0), .PO_VALID(po_valid0), .PO_READY(po_ready),
    .OVERRUN(overrun0), .FRAMEERR(frameerr0), .ERR_CLR(err_clr)
  );

  shift_deserializer #(.WIDTH(8), .FREERUN(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clken(clken && sel1), .SI(si), .SYNC(sync),
    .PO(po1), .PO_VALID(po_valid1), .PO_READY(po_ready),
    .OVERRUN(overrun1), .FRAMEERR(frameerr1), .ERR_CLR(err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge that samples them
  task automatic drive(input logic en, input logic s, input logic y);
    clken = en;
    si    = s;
    sync  = y;
    @(posedge clk);
    #1;
    clken = 1'b0;
    sync  = 1'b0;
    si    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] d, input int nbits, input bit with_sync, input bit toggle);
    for (int i = 7; i > 7 - nbits; i--) begin
      drive(1'b1, d[i], with_sync && (i == 7));
      if (toggle && (i > 8 - nbits)) drive(1'b0, ~d[i], 1'b1);
    end
  endtask

  // Scoreboard monitor: a handshake happens on the next rising edge
  always @(negedge clk) begin
    logic [7:0] e;
    if (po_valid0 && po_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0_unexpected_word: got %0h expected none", po0);
      end else begin
        e = q0.pop_front();
        if (po0 !== e) begin
          errors++;
          $display("FAIL dut0_word: got %0h expected %0h", po0, e);
        end
      end
    end
    if (po_valid1 && po_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected_word: got %0h expected none", po1);
      end else begin
        e = q1.pop_front();
        if (po1 !== e) begin
          errors++;
          $display("FAIL dut1_word: got %0h expected %0h", po1, e);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clken = 1'b0; si = 1'b0; sync = 1'b0;
    po_ready = 1'b0; err_clr = 1'b0; sel1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_po0", po0, 8'h00);
    check("rst_valid0", po_valid0, 1'b0);
    check("rst_overrun0", overrun0, 1'b0);
    check("rst_frameerr0", frameerr0, 1'b0);
    check("rst_valid1", po_valid1, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // 1: basic word
    po_ready = 1'b1;
    q0.push_back(8'hA5);
    send(8'hA5, 8, 1'b1, 1'b0);
    check("t1_valid", po_valid0, 1'b1);
    check("t1_po", po0, 8'hA5);
    idle(1);
    check("t1_valid_drop", po_valid0, 1'b0);
    check("t1_po_hold", po0, 8'hA5);

    // 2: clken toggling, SYNC/SI noise while clken=0
    q0.push_back(8'h3C);
    send(8'h3C, 8, 1'b1, 1'b1);
    check("t2_valid", po_valid0, 1'b1);
    check("t2_po", po0, 8'h3C);
    check("t2_frameerr", frameerr0, 1'b0);
    idle(2);

    // 3: overrun
    po_ready = 1'b0;
    q0.push_back(8'h11);
    send(8'h11, 8, 1'b1, 1'b0);
    send(8'h22, 8, 1'b1, 1'b0);
    check("t3_po_kept", po0, 8'h11);
    check("t3_valid", po_valid0, 1'b1);
    check("t3_overrun", overrun0, 1'b1);
    po_ready = 1'b1;
    idle(1);
    check("t3_valid_drop", po_valid0, 1'b0);
    check("t3_overrun_sticky", overrun0, 1'b1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t3_overrun_clr", overrun0, 1'b0);

    // 4: early re-sync
    send(8'hA0, 3, 1'b1, 1'b0);
    q0.push_back(8'hF0);
    send(8'hF0, 8, 1'b1, 1'b0);
    check("t4_frameerr", frameerr0, 1'b1);
    check("t4_po", po0, 8'hF0);
    check("t4_valid", po_valid0, 1'b1);
    idle(2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("t4_frameerr_clr", frameerr0, 1'b0);

    // 5: free-running back-to-back words on dut1
    sel1 = 1'b1;
    q1.push_back(8'hDE);
    q1.push_back(8'hAD);
    q1.push_back(8'hBE);
    send(8'hDE, 8, 1'b1, 1'b0);
    check("t5_po_de", po1, 8'hDE);
    send(8'hAD, 8, 1'b0, 1'b0);
    check("t5_po_ad", po1, 8'hAD);
    check("t5_valid_ad", po_valid1, 1'b1);
    send(8'hBE, 8, 1'b0, 1'b0);
    check("t5_po_be", po1, 8'hBE);
    check("t5_frameerr1", frameerr1, 1'b0);
    check("t5_overrun1", overrun1, 1'b0);
    idle(1);
    check("t5_valid1_drop", po_valid1, 1'b0);
    sel1 = 1'b0;
    send(8'hFF, 8, 1'b0, 1'b0);
    idle(2);
    check("t5_hunt_ignored", po_valid0, 1'b0);

    // 6: async reset mid-word and mid-valid
    po_ready = 1'b0;
    send(8'h77, 8, 1'b1, 1'b0);
    check("t6_valid_pre", po_valid0, 1'b1);
    send(8'h5A, 4, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_po", po0, 8'h00);
    check("t6_rst_valid", po_valid0, 1'b0);
    check("t6_rst_overrun", overrun0, 1'b0);
    check("t6_rst_po1", po1, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    po_ready = 1'b1;
    q0.push_back(8'h5A);
    send(8'h5A, 8, 1'b1, 1'b0);
    check("t6_po", po0, 8'h5A);
    check("t6_frameerr", frameerr0, 1'b0);
    idle(3);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
